seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the game's multiplexed 4-digit 7-segment driver. Samples the scanned digit_sel/segments bus, waits for it to settle, and decodes each pattern back to a 4-bit symbol code.
- Collects one symbol per digit and publishes complete 4-digit frames with valid/changed strobes.
- Used as an on-chip display monitor for scoreboard/self-test and as the bench-side checker model.

Parameters:
- SETTLE_CYCLES, 16: consecutive cycles the synchronized bus must hold unchanged before it is sampled (min 2).
- TIMEOUT_CYCLES, 262144: cycles without any slot write before `active` drops.
- SEG_ACTIVE_LOW, 1: 1 means a segment or dp bit is lit when 0.
- DIG_ACTIVE_LOW, 1: 1 means a digit is selected when its digit_sel bit is 0.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- digit_sel  in  4  scanned digit enables; bit0 is slot0, the rightmost digit.
- segments  in  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- sym_out  out  16  published frame; slot n at [4n+3:4n].
- dp_out  out  4  published decimal-point state per slot, 1 = lit.
- frame_valid  out  1  one-cycle pulse when sym_out/dp_out update.
- changed  out  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous one.
- active  out  1  high while slot writes are occurring.
- err_multi  out  1  sticky flag: a sample had more than one digit selected.
- frame_count  out  16  frames published (only with optional feature).

Behaviour:
- Reset values:
  - sym_out = 16'hDDDD (all blank); dp_out = 0.
  - frame_valid, changed, active, err_multi = 0; frame_count = 0.
  - Internal sync, count and seen-mask registers cleared.
- Synchronization: both buses pass through 2 flops. The stable word is s = {digit_sel, segments} after stage 2.
- Settle counter:
  - s_prev is registered each cycle.
  - If s != s_prev, cnt <= 0. Otherwise cnt increments, saturating at SETTLE_CYCLES.
  - Capture strobe fires once, on the edge where cnt goes from SETTLE_CYCLES-1 to SETTLE_CYCLES.
  - An input change sampled at edge k is captured at edge k+SETTLE_CYCLES+2.
  - A bus held stable indefinitely is captured exactly once. Any glitch restarts the count.
- Normalization: invert segments if SEG_ACTIVE_LOW; invert digit_sel if DIG_ACTIVE_LOW. The result is lit-high.
- Decode of segments[6:0] (lit-high, gfedcba) to a 4-bit code:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 38→A ('L'), 76→B ('H'), 40→C ('-'), 00→D (blank).
  - Any other pattern →F (unknown).
- Capture action, by count of selected digits:
  - Exactly one digit selected: write code and dp into the shadow slot, set that seen bit, clear the timeout counter. Rewriting a slot before the frame completes overwrites it without error.
  - Zero digits selected: ignored; no write.
  - Two or more selected: no write; set err_multi, which clears only on reset.
- Frame publish:
  - Trigger: the capture makes seen == 4'b1111.
  - Next edge: copy shadow to sym_out/dp_out, pulse frame_valid for 1 cycle, clear seen.
  - changed = 1 if the new {sym,dp} != previous published value, or if this is the first frame after reset.
- Simultaneous events: a capture in the same cycle as a publish is kept. Its seen bit is set after the clear, so it starts the next frame.
- Timeout:
  - tcnt increments each cycle without a slot write, saturating at TIMEOUT_CYCLES.
  - active = 1 after any slot write; active = 0 when tcnt reaches TIMEOUT_CYCLES.
  - Timeout does not clear seen or sym_out.
- Reset mid-frame: partial shadow contents are discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: SEG_SCAN_FRAME_CNT_EN.
- Defined: frame_count increments on every frame_valid and wraps 16'hFFFF→0.
- Undefined: frame_count is tied to 0 and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Basic decode: reset, then drive the driver-style scan, each digit held 200 cycles, with active-low {1110:F9, 1101:FF, 1011:FF, 0111:C0}.
  - Expect sym_out=16'h0DD1 and dp_out=0.
  - Expect frame_valid plus changed exactly once per scan.
  - Repeating the identical scan gives frame_valid with changed=0.
- Latency: single stable word applied at edge k with SETTLE_CYCLES=16.
  - Slot write at edge k+18.
  - Hold for 1000 cycles: no second capture.
  - Glitch for 5 cycles: count restarts.
- Symbols: scan L(C7), o(C0), H(89), bar(BF) across slots 0..3 → sym_out=16'hCB0A. Pattern 8'hAA on slot 2 → nibble F.
- Error handling:
  - digit_sel=4'b1100 stable → err_multi=1 with no slot write.
  - Reset → err_multi=0.
  - digit_sel=4'b1111 → ignored; no write, no error.
- Partial frame and timeout:
  - Scan only slots 0-2, then idle → no frame_valid; active falls TIMEOUT_CYCLES after the last write.
  - A later slot-3 write publishes the frame.
  - Reset asserted mid-frame → sym_out=16'hDDDD.
- Frame counter: with SEG_SCAN_FRAME_CNT_EN, after 3 full scans frame_count=3. Preset the count via 65536 frames (or force) to observe the wrap. Without the macro, frame_count stays 0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a multiplexed 4-digit
// 7-segment bus. It synchronizes and debounces the {digit_sel, segments}
// word, decodes each settled pattern back to a 4-bit symbol and publishes
// complete 4-digit frames with valid/changed strobes.
//
// Optional build feature: define SEG_SCAN_FRAME_CNT_EN to get a wrapping
// 16-bit published-frame counter on frame_count. Without it frame_count
// is tied to zero and no counter logic exists.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 262144,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit_sel,
  input  logic [7:0]  segments,
  output logic [15:0] sym_out,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        changed,
  output logic        active,
  output logic        err_multi,
  output logic [15:0] frame_count
);

  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_FIRE  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  // Lit-high gfedcba pattern to symbol code; anything unrecognised is F.
  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    logic [3:0] c;
    case (p)
      7'h3F:   c = 4'h0;
      7'h06:   c = 4'h1;
      7'h5B:   c = 4'h2;
      7'h4F:   c = 4'h3;
      7'h66:   c = 4'h4;
      7'h6D:   c = 4'h5;
      7'h7D:   c = 4'h6;
      7'h07:   c = 4'h7;
      7'h7F:   c = 4'h8;
      7'h6F:   c = 4'h9;
      7'h38:   c = 4'hA;   // 'L'
      7'h76:   c = 4'hB;   // 'H'
      7'h40:   c = 4'hC;   // '-'
      7'h00:   c = 4'hD;   // blank
      default: c = 4'hF;
    endcase
    return c;
  endfunction

  // Number of digits selected in a lit-high digit mask.
  function automatic logic [2:0] sel_count(input logic [3:0] d);
    return {2'b00, d[0]} + {2'b00, d[1]} + {2'b00, d[2]} + {2'b00, d[3]};
  endfunction

  logic [11:0]       sync_p0, sync_p1, s_prev;
  logic [CNT_W-1:0]  cnt;
  logic              stable, capture;
  logic [3:0]        dig_lit;
  logic [7:0]        seg_lit;
  logic [2:0]        sel_n;
  logic [3:0]        code;
  logic [3:0]        wr_mask;
  logic              multi_hit;
  logic [3:0]        seen, seen_next;
  logic              pub_trig, pub_vld_p0;
  logic [15:0]       shadow_sym;
  logic [3:0]        shadow_dp;
  logic              pub_once;
  logic [TCNT_W-1:0] tcnt;

  // Settle detection, normalization, decode and frame-complete detection.
  always_comb begin
    stable    = (sync_p1 == s_prev);
    capture   = stable && (cnt == CNT_FIRE);
    dig_lit   = (DIG_ACTIVE_LOW != 0) ? ~sync_p1[11:8] : sync_p1[11:8];
    seg_lit   = (SEG_ACTIVE_LOW != 0) ? ~sync_p1[7:0]  : sync_p1[7:0];
    sel_n     = sel_count(dig_lit);
    code      = seg_decode(seg_lit[6:0]);
    wr_mask   = 4'h0;
    multi_hit = 1'b0;
    if (capture) begin
      if (sel_n == 3'd1)      wr_mask   = dig_lit;
      else if (sel_n >= 3'd2) multi_hit = 1'b1;
    end
    // A capture landing on the publish cycle starts the next frame.
    seen_next = (pub_vld_p0 ? 4'h0 : seen) | wr_mask;
    pub_trig  = (wr_mask != 4'h0) && (seen_next == 4'hF);
  end

  // Two-flop synchronizer, previous-word register and saturating settle count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      s_prev  <= '0;
      cnt     <= '0;
    end else begin
      sync_p0 <= {digit_sel, segments};
      sync_p1 <= sync_p0;
      s_prev  <= sync_p1;
      if (!stable)             cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow slot writes, seen mask and the publish request for the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_sym <= 16'hDDDD;
      shadow_dp  <= 4'h0;
      seen       <= 4'h0;
      pub_vld_p0 <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          shadow_sym[4*i +: 4] <= code;
          shadow_dp[i]         <= seg_lit[7];
        end
      end
      seen       <= seen_next;
      pub_vld_p0 <= pub_trig;
    end
  end

  // ---- publish stage: shadow copied to outputs one edge after completion ----
  // Published frame registers and the valid/changed strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_out     <= 16'hDDDD;
      dp_out      <= 4'h0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      pub_once    <= 1'b0;
    end else begin
      frame_valid <= pub_vld_p0;
      changed     <= pub_vld_p0 &&
                     (!pub_once || ({shadow_sym, shadow_dp} != {sym_out, dp_out}));
      if (pub_vld_p0) begin
        sym_out  <= shadow_sym;
        dp_out   <= shadow_dp;
        pub_once <= 1'b1;
      end
    end
  end

  // Activity timeout: any slot write re-arms, silence for TIMEOUT_CYCLES drops active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt   <= '0;
      active <= 1'b0;
    end else if (wr_mask != 4'h0) begin
      tcnt   <= '0;
      active <= 1'b1;
    end else if (tcnt != TCNT_MAX) begin
      tcnt <= tcnt + TCNT_W'(1);
      if (tcnt == TCNT_LAST) active <= 1'b0;
    end
  end

  // Sticky multi-select error, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          err_multi <= 1'b0;
    else if (multi_hit) err_multi <= 1'b1;
  end

`ifdef SEG_SCAN_FRAME_CNT_EN
  logic [15:0] fcnt;

  // Published-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           fcnt <= 16'h0;
    else if (pub_vld_p0) fcnt <= fcnt + 16'h1;
  end

  assign frame_count = fcnt;
`else
  assign frame_count = 16'h0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed bench for seg_scan_decoder with
// hand-computed expectations. TIMEOUT_CYCLES is shortened so the
// activity timeout can be observed in a short run.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 400;

  logic        clk;
  logic        reset;
  logic [3:0]  digit_sel;
  logic [7:0]  segments;
  logic [15:0] sym_out;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        changed;
  logic        active;
  logic        err_multi;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;
  int ch_cnt = 0;
  int fv0, ch0;

  seg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_sel  (digit_sel),
    .segments   (segments),
    .sym_out    (sym_out),
    .dp_out     (dp_out),
    .frame_valid(frame_valid),
    .changed    (changed),
    .active     (active),
    .err_multi  (err_multi),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (changed)     ch_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] seg);
    digit_sel = sel;
    segments  = seg;
  endtask

  task automatic do_reset();
    drive(4'hF, 8'hFF);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  // Driver-style scan, slot 0 first, each digit held 200 cycles.
  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    drive(4'b1110, s0); tick(200);
    drive(4'b1101, s1); tick(200);
    drive(4'b1011, s2); tick(200);
    drive(4'b0111, s3); tick(200);
  endtask

  task automatic mark();
    fv0 = fv_cnt;
    ch0 = ch_cnt;
  endtask

  initial begin
    reset = 1'b0;
    drive(4'hF, 8'hFF);
    tick(1);

    // Reset state
    do_reset();
    check("rst_sym",    32'(sym_out),     32'hDDDD);
    check("rst_dp",     32'(dp_out),      32'h0);
    check("rst_fv",     32'(frame_valid), 32'h0);
    check("rst_chg",    32'(changed),     32'h0);
    check("rst_active", 32'(active),      32'h0);
    check("rst_err",    32'(err_multi),   32'h0);
    check("rst_fcnt",   32'(frame_count), 32'h0);

    // Basic decode and repeat-without-change
    mark();
    scan(8'hF9, 8'hFF, 8'hFF, 8'hC0);
    check("basic_sym", 32'(sym_out), 32'h0DD1);
    check("basic_dp",  32'(dp_out),  32'h0);
    check("basic_fv",  32'(fv_cnt - fv0), 32'd1);
    check("basic_chg", 32'(ch_cnt - ch0), 32'd1);
    check("basic_active", 32'(active), 32'h1);
    mark();
    scan(8'hF9, 8'hFF, 8'hFF, 8'hC0);
    check("repeat_sym", 32'(sym_out), 32'h0DD1);
    check("repeat_fv",  32'(fv_cnt - fv0), 32'd1);
    check("repeat_chg", 32'(ch_cnt - ch0), 32'd0);

    // Digits 2..9
    mark();
    scan(8'hA4, 8'hB0, 8'h99, 8'h92);
    check("dig2345_sym", 32'(sym_out), 32'h5432);
    scan(8'h82, 8'hF8, 8'h80, 8'h90);
    check("dig6789_sym", 32'(sym_out), 32'h9876);
    check("dig_fv",  32'(fv_cnt - fv0), 32'd2);
    check("dig_chg", 32'(ch_cnt - ch0), 32'd2);

    // Letters, unknown pattern and a lit decimal point
    scan(8'hC7, 8'hC0, 8'h89, 8'hBF);
    check("sym_LoHbar", 32'(sym_out), 32'hCB0A);
    check("sym_dp0",    32'(dp_out),  32'h0);
    scan(8'hC7, 8'h40, 8'hAA, 8'hBF);
    check("sym_unknown", 32'(sym_out), 32'hCF0A);
    check("sym_dp1",     32'(dp_out),  32'h2);

    // Capture latency, single capture of a held word, activity timeout, glitch
    do_reset();
    drive(4'b1110, 8'hF9);
    tick(18);
    check("lat_before", 32'(active), 32'h0);
    tick(1);
    check("lat_at",     32'(active), 32'h1);
    tick(399);
    check("tmo_before", 32'(active), 32'h1);
    tick(1);
    check("tmo_at",     32'(active), 32'h0);
    tick(600);
    check("hold_once",  32'(active), 32'h0);
    drive(4'b1110, 8'hFF);
    tick(5);
    drive(4'b1110, 8'hF9);
    tick(18);
    check("glitch_before", 32'(active), 32'h0);
    tick(1);
    check("glitch_at",     32'(active), 32'h1);

    // Multi-select error, cleared by reset; no-select ignored
    do_reset();
    mark();
    drive(4'b1100, 8'hF9);
    tick(60);
    check("multi_err",    32'(err_multi), 32'h1);
    check("multi_nowr",   32'(active),    32'h0);
    do_reset();
    check("multi_rst",    32'(err_multi), 32'h0);
    drive(4'b1111, 8'hC0);
    tick(60);
    check("none_err",     32'(err_multi), 32'h0);
    check("none_nowr",    32'(active),    32'h0);
    check("err_fv",       32'(fv_cnt - fv0), 32'd0);

    // Partial frame, timeout after last write, late slot 3 completes
    mark();
    drive(4'b1110, 8'hF9); tick(200);
    drive(4'b1101, 8'hA4); tick(200);
    drive(4'b1011, 8'hB0); tick(200);
    drive(4'b1111, 8'hFF); tick(218);
    check("part_act_before", 32'(active), 32'h1);
    tick(1);
    check("part_act_drop",   32'(active), 32'h0);
    check("part_fv",  32'(fv_cnt - fv0), 32'd0);
    check("part_sym", 32'(sym_out), 32'hDDDD);
    drive(4'b0111, 8'h99); tick(200);
    check("late_fv",  32'(fv_cnt - fv0), 32'd1);
    check("late_sym", 32'(sym_out), 32'h4321);
    check("late_act", 32'(active), 32'h1);

    // Reset mid-frame: outputs clear at once, partial shadow discarded
    drive(4'b1110, 8'hC0);
    tick(100);
    reset = 1'b1;
    #1;
    check("midrst_sym", 32'(sym_out), 32'hDDDD);
    check("midrst_dp",  32'(dp_out),  32'h0);
    check("midrst_act", 32'(active),  32'h0);
    drive(4'hF, 8'hFF);
    tick(3);
    reset = 1'b0;
    tick(1);
    mark();
    drive(4'b1101, 8'hA4); tick(200);
    drive(4'b1011, 8'hB0); tick(200);
    drive(4'b0111, 8'h99); tick(200);
    check("midrst_nofv", 32'(fv_cnt - fv0), 32'd0);

    // Frame counter
    do_reset();
    scan(8'hF9, 8'hFF, 8'hFF, 8'hC0);
    scan(8'hA4, 8'hB0, 8'h99, 8'h92);
    scan(8'hF9, 8'hFF, 8'hFF, 8'hC0);
`ifdef SEG_SCAN_FRAME_CNT_EN
    check("fcnt", 32'(frame_count), 32'd3);
`else
    check("fcnt", 32'(frame_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
